// File: rtl/wb_sram_burst_slave_if.sv
// Wishbone B4 bus bundle with registered-feedback burst tags (CTI/BTE).
// Master drives the request side; slave returns data and ACK/ERR.
interface wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   ADR;
  logic [2:0]              CTI;
  logic [1:0]              BTE;
  logic [DATA_WIDTH-1:0]   DAT_W;
  logic [DATA_WIDTH-1:0]   DAT_R;
  logic [DATA_WIDTH/8-1:0] SEL;
  logic                    CYC;
  logic                    STB;
  logic                    WE;
  logic                    ACK;
  logic                    ERR;

  modport master (
    output ADR, CTI, BTE, DAT_W, CYC, SEL, STB, WE,
    input  DAT_R, ACK, ERR
  );

  modport slave (
    input  ADR, CTI, BTE, DAT_W, CYC, SEL, STB, WE,
    output DAT_R, ACK, ERR
  );
endinterface

// File: rtl/wb_sram_burst_slave.sv
// Wishbone SRAM target: classic cycles with one wait state, incrementing
// bursts (linear, wrap-4/8/16) at one beat per clock, ERR outside the window.
module wb_sram_burst_slave #(
  parameter int                       WB_ADDR_WIDTH = 32,
  parameter int                       WB_DATA_WIDTH = 32,
  parameter int                       MEM_ADDR_BITS = 10,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = '0
) (
  input logic clk,
  input logic rstn,
  wb_if.slave s
);
  localparam int LANES    = WB_DATA_WIDTH / 8;
  localparam int OB       = $clog2(LANES);
  localparam int DEPTH    = 1 << MEM_ADDR_BITS;
  localparam int WIN_BITS = MEM_ADDR_BITS + OB;

  typedef enum logic [1:0] {IDLE, SINGLE, BURST, ERRS} state_t;

  state_t                   state_reg;
  logic                     ack_reg;
  logic                     err_reg;
  logic [WB_DATA_WIDTH-1:0] dat_r_reg;
  logic [MEM_ADDR_BITS-1:0] baddr_reg;
  logic [WB_DATA_WIDTH-1:0] mem [DEPTH];

  logic [WB_ADDR_WIDTH-1:0] offset;
  logic                     in_window;
  logic                     req;
  logic                     bus_ok;
  logic                     ack;
  logic                     err;
  logic                     beat_more;
  logic [MEM_ADDR_BITS-1:0] req_waddr;
  logic [MEM_ADDR_BITS-1:0] wrap_mask;
  logic [MEM_ADDR_BITS-1:0] baddr_inc;
  logic [MEM_ADDR_BITS-1:0] baddr_next;
  logic                     mem_we;
  logic                     mem_re;
  logic [MEM_ADDR_BITS-1:0] mem_addr;

  assign offset    = s.ADR - BASE_ADDR;
  assign in_window = (offset >> WIN_BITS) == '0;
  assign req_waddr = s.ADR[OB +: MEM_ADDR_BITS];
  assign req       = s.CYC & s.STB;
  // Reset and abort both suppress the handshake in the very cycle they occur.
  assign bus_ok    = rstn & s.CYC & s.STB;
  assign ack       = ack_reg & bus_ok;
  assign err       = err_reg & bus_ok;
  assign beat_more = (s.CTI == 3'b010);

  assign s.ACK   = ack;
  assign s.ERR   = err;
  assign s.DAT_R = dat_r_reg;

  // Wrap bursts only advance the low 2/3/4 bits; upper bits stay put.
  always_comb begin
    wrap_mask = '1;
    case (s.BTE)
      2'b01:   wrap_mask = MEM_ADDR_BITS'(3);
      2'b10:   wrap_mask = MEM_ADDR_BITS'(7);
      2'b11:   wrap_mask = MEM_ADDR_BITS'(15);
      default: wrap_mask = '1;
    endcase
    baddr_inc  = baddr_reg + MEM_ADDR_BITS'(1);
    baddr_next = (baddr_reg & ~wrap_mask) | (baddr_inc & wrap_mask);
  end

  // Single memory port: a write beat owns the port, otherwise it prefetches.
  always_comb begin
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_addr = baddr_reg;
    case (state_reg)
      IDLE: begin
        if (req && in_window) begin
          mem_re   = 1'b1;
          mem_addr = req_waddr;
        end
      end
      SINGLE: mem_we = ack & s.WE;
      BURST: begin
        if (ack && s.WE) begin
          mem_we = 1'b1;
        end else if (ack && beat_more) begin
          mem_re   = 1'b1;
          mem_addr = baddr_next;
        end else if (s.CYC && !s.STB) begin
          mem_re = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (mem_we && s.SEL[i]) begin
        mem[mem_addr][8*i +: 8] <= s.DAT_W[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= IDLE;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      dat_r_reg <= '0;
      baddr_reg <= '0;
    end else begin
      if (mem_re) begin
        dat_r_reg <= mem[mem_addr];
      end
      case (state_reg)
        IDLE: begin
          if (req) begin
            baddr_reg <= req_waddr;
            if (!in_window) begin
              err_reg   <= 1'b1;
              state_reg <= ERRS;
            end else begin
              ack_reg   <= 1'b1;
              state_reg <= beat_more ? BURST : SINGLE;
            end
          end
        end
        SINGLE: begin
          ack_reg   <= 1'b0;
          state_reg <= IDLE;
        end
        ERRS: begin
          err_reg   <= 1'b0;
          state_reg <= IDLE;
        end
        BURST: begin
          if (!s.CYC || (ack && !beat_more)) begin
            ack_reg   <= 1'b0;
            state_reg <= IDLE;
          end else if (ack) begin
            baddr_reg <= baddr_next;
          end
        end
        default: begin
          ack_reg   <= 1'b0;
          err_reg   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_sram_burst_slave.sv
// Bench for wb_sram_burst_slave: bus tasks push expected responses into a
// queue, a negedge monitor pops and compares them as ACK/ERR appear.
module tb_wb_sram_burst_slave;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MAB = 10;
  localparam logic [31:0] WIN_BYTES = 32'h1000;

  typedef struct {
    bit          is_err;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wb_sram_burst_slave #(
    .WB_ADDR_WIDTH (AW),
    .WB_DATA_WIDTH (DW),
    .MEM_ADDR_BITS (MAB),
    .BASE_ADDR     (32'h0)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .s    (bus)
  );

  exp_t        sb_q[$];
  logic [31:0] model [1024];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.ACK === 1'b1 || bus.ERR === 1'b1) begin
      check_eq("ack_err_exclusive", 32'(bus.ACK & bus.ERR), 32'd0);
      check_eq("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("resp_is_err", 32'(bus.ERR), 32'(e.is_err));
        if (e.chk) check_eq("read_data", bus.DAT_R, e.data);
      end
    end
  end

  task automatic idle_bus();
    bus.CYC = 1'b0;
    bus.STB = 1'b0;
    bus.WE  = 1'b0;
    bus.CTI = 3'b000;
    bus.BTE = 2'b00;
    bus.SEL = 4'hF;
  endtask

  task automatic classic(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                         input logic [3:0] sel);
    exp_t e;
    bit   oow;
    int   w;
    oow = (adr >= WIN_BYTES);
    w   = int'(adr[11:2]);
    bus.CYC = 1'b1; bus.STB = 1'b1; bus.WE = we; bus.ADR = adr;
    bus.DAT_W = wd; bus.SEL = sel; bus.CTI = 3'b000; bus.BTE = 2'b00;
    e.is_err = oow;
    e.chk    = !we && !oow;
    e.data   = we ? 32'h0 : model[w];
    if (we && !oow) begin
      for (int i = 0; i < 4; i++) if (sel[i]) model[w][8*i +: 8] = wd[8*i +: 8];
    end
    sb_q.push_back(e);
    $display("classic %s adr=0x%08h wd=0x%08h sel=%b", we ? "WR" : "RD", adr, wd, sel);
    @(negedge clk);
    check_eq("classic_t0_idle", {30'b0, bus.ACK, bus.ERR}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("classic_t1_ack", 32'(bus.ACK), 32'(!oow));
    check_eq("classic_t1_err", 32'(bus.ERR), 32'(oow));
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic burst(input bit we, input logic [31:0] adr, input int n, input logic [1:0] bte,
                       input logic [31:0] wbase, input logic [31:0] wstep,
                       input int stall_at, input int stall_len,
                       input int abort_at, input bit abort_rst);
    exp_t e;
    int   start;
    int   mask;
    int   w;
    start = int'(adr[11:2]);
    mask  = (bte == 2'b00) ? 1023 : (bte == 2'b01) ? 3 : (bte == 2'b10) ? 7 : 15;
    $display("burst %s adr=0x%08h beats=%0d bte=%b stall_at=%0d abort_at=%0d rst=%0d",
             we ? "WR" : "RD", adr, n, bte, stall_at, abort_at, abort_rst);
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (k == stall_at) begin
          bus.STB = 1'b0;
          repeat (stall_len) begin
            @(negedge clk);
            check_eq("burst_stall_no_ack", 32'(bus.ACK), 32'd0);
            @(posedge clk); #1;
          end
          bus.STB = 1'b1;
        end
        if (k == abort_at) begin
          if (abort_rst) rstn = 1'b0;
          else begin
            bus.CYC = 1'b0;
            bus.STB = 1'b0;
          end
          @(negedge clk);
          check_eq("burst_abort_no_ack", 32'(bus.ACK), 32'd0);
          @(posedge clk); #1;
          rstn = 1'b1;
          idle_bus();
          return;
        end
      end
      w = (start & ~mask) | ((start + k) & mask);
      bus.CYC   = 1'b1;
      bus.STB   = 1'b1;
      bus.WE    = we;
      bus.ADR   = (k == 0) ? adr : 32'hDEAD_0000;
      bus.CTI   = (k == n - 1) ? 3'b111 : 3'b010;
      bus.BTE   = bte;
      bus.SEL   = 4'hF;
      bus.DAT_W = wbase + wstep * k;
      e.is_err  = 1'b0;
      e.chk     = !we;
      e.data    = model[w];
      if (we) model[w] = wbase + wstep * k;
      sb_q.push_back(e);
      if (k == 0) begin
        @(negedge clk);
        check_eq("burst_t0_idle", 32'(bus.ACK), 32'd0);
        @(posedge clk); #1;
      end
      @(negedge clk);
      check_eq("burst_beat_ack", 32'(bus.ACK), 32'd1);
    end
    @(posedge clk); #1;
    idle_bus();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_bus();
    bus.ADR   = 32'h0;
    bus.DAT_W = 32'h0;
    rstn      = 1'b0;

    // Request held active through reset must see no handshake.
    bus.CYC = 1'b1; bus.STB = 1'b1; bus.WE = 1'b1;
    bus.ADR = 32'h10; bus.DAT_W = 32'hDEADBEEF; bus.SEL = 4'hF;
    repeat (3) begin
      @(negedge clk);
      check_eq("reset_ack", 32'(bus.ACK), 32'd0);
      check_eq("reset_err", 32'(bus.ERR), 32'd0);
      check_eq("reset_dat_r", bus.DAT_R, 32'd0);
    end
    @(posedge clk); #1;
    rstn = 1'b1;

    classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    classic(1'b1, 32'h10, 32'h000000AA, 4'b0001);
    classic(1'b0, 32'h10, 32'h0, 4'hF);

    burst(1'b1, 32'h0, 8, 2'b00, 32'h0, 32'h11111111, -1, 0, -1, 1'b0);
    burst(1'b0, 32'h0, 8, 2'b00, 32'h0, 32'h0, -1, 0, -1, 1'b0);

    classic(1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF);
    burst(1'b0, 32'hFFC, 2, 2'b00, 32'h0, 32'h0, -1, 0, -1, 1'b0);

    burst(1'b0, 32'h18, 4, 2'b01, 32'h0, 32'h0, 2, 2, -1, 1'b0);
    burst(1'b0, 32'h14, 8, 2'b10, 32'h0, 32'h0, -1, 0, -1, 1'b0);

    classic(1'b1, 32'h1000, 32'h12345678, 4'hF);
    classic(1'b0, 32'h0, 32'h0, 4'hF);
    classic(1'b0, 32'h2000, 32'h0, 4'hF);

    burst(1'b1, 32'h0, 4, 2'b00, 32'hA0000000, 32'h1, -1, 0, 2, 1'b0);
    classic(1'b0, 32'h0, 32'h0, 4'hF);
    classic(1'b0, 32'h4, 32'h0, 4'hF);
    classic(1'b0, 32'h8, 32'h0, 4'hF);

    burst(1'b1, 32'h0, 4, 2'b00, 32'hB0000000, 32'h1, -1, 0, 2, 1'b1);
    classic(1'b0, 32'h0, 32'h0, 4'hF);
    classic(1'b0, 32'h4, 32'h0, 4'hF);
    classic(1'b0, 32'h8, 32'h0, 4'hF);

    repeat (2) @(posedge clk);
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
